// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state type and address-field helpers for the data cache
package dcache_pkg;
  localparam int OFFSET_W = 5;
  localparam int INDEX_W = 5;
  localparam int TAG_W = 22;
  localparam int LINE_BITS = 256;
  localparam int NUM_LINES = 1 << INDEX_W;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, ALLOCATE, REFILLED} state_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [INDEX_W-1:0] idx;
    logic [2:0] word;
    logic [1:0] byte_sel;
  } addr_t;
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: per-line valid/dirty/tag/data storage, combinational read, word or full-line write
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   idx,
  input  logic                 word_we,
  input  logic [2:0]           word,
  input  logic [31:0]          word_data,
  input  logic                 fill,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_W-1:0]     tag,
  output logic [LINE_BITS-1:0] line
);
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [LINE_BITS-1:0] line_q [NUM_LINES];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag = tag_q[idx];
  assign line = line_q[idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) dirty_q[idx] <= 1'b1;
  end
  // data array carries no reset; contents are only trusted behind valid
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx] <= fill_tag;
      line_q[idx] <= fill_line;
    end else if (word_we) line_q[idx][{word, 5'b0} +: 32] <= word_data;
  end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache with miss FSM
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  addr_t a;
  state_t state, next;
  logic req, hit, ack, valid, dirty, victim_dirty, unused;
  logic [TAG_W-1:0] tag;
  logic [LINE_BITS-1:0] line;
  assign a = p1_addr_i;
  assign unused = ^a.byte_sel;
  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign ack = mem_ack_i & mem_enable_o;
  assign hit = valid & (tag == a.tag);
  assign victim_dirty = valid & dirty;
  assign p1_stall_o = req & ((state != IDLE) | ~hit);
  assign p1_data_o = valid ? line[{a.word, 5'b0} +: 32] : '0;
  dcache_sram u_sram (
    .clk(clk_i),
    .rst(rst_i),
    .idx(a.idx),
    .word_we(state == IDLE && p1_MemWrite_i && hit),
    .word(a.word),
    .word_data(p1_data_i),
    .fill(state == ALLOCATE && ack),
    .fill_tag(a.tag),
    .fill_line(mem_data_i),
    .valid(valid),
    .dirty(dirty),
    .tag(tag),
    .line(line)
  );
  always_comb begin
    next = state == IDLE      ? (req && !hit ? MISS : IDLE) :
           state == MISS      ? (victim_dirty ? WRITEBACK : ALLOCATE) :
           state == WRITEBACK ? (ack ? ALLOCATE : WRITEBACK) :
           state == ALLOCATE  ? (ack ? REFILLED : ALLOCATE) : IDLE;
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : next;
  // memory request is launched from MISS while the victim tag/line are still in storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (state == MISS) begin
      mem_enable_o <= 1'b1;
      mem_write_o <= victim_dirty;
      mem_addr_o <= line_addr(victim_dirty ? tag : a.tag, a.idx);
      mem_data_o <= line;
    end else if (state == WRITEBACK && ack) begin
      mem_write_o <= 1'b0;
      mem_addr_o <= line_addr(a.tag, a.idx);
    end else if (state == ALLOCATE && ack) mem_enable_o <= 1'b0;
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed table, reset-abort sequence and random ops against a cache model
module tb_dcache_controller;
  localparam int LAT = 10;
  logic clk = 0, rst = 1;
  logic [31:0] addr = 0, wdata = 0;
  logic mr = 0, mw = 0;
  logic [31:0] p1_data, mem_addr;
  logic stall, mem_en, mem_wr;
  logic [255:0] mem_wdata, mem_rdata = '0;
  logic ack = 0;
  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(addr), .p1_data_i(wdata),
    .p1_MemRead_i(mr), .p1_MemWrite_i(mw), .p1_data_o(p1_data), .p1_stall_o(stall),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_enable_o(mem_en),
    .mem_write_o(mem_wr), .mem_data_i(mem_rdata), .mem_ack_i(ack)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic w; logic [31:0] a; logic [255:0] d;} txn_t;
  txn_t txq[$];
  logic [255:0] mem [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a == 32'h408 ? 32'hAA : {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction
  function automatic logic [255:0] pat_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = pat(la + 32'(k * 4));
    return l;
  endfunction

  int cnt = 0, en_rises = 0;
  logic prev_en = 0, auto_en = 1, man_ack = 0;
  always @(negedge clk) begin
    if (mem_en && !prev_en) en_rises++;
    prev_en = mem_en;
    if (ack) ack = 0;
    else if (man_ack) ack = 1;
    else if (auto_en && mem_en) begin
      cnt++;
      if (cnt == LAT) begin
        cnt = 0;
        ack = 1;
        txq.push_back('{w: mem_wr, a: mem_addr, d: mem_wdata});
        if (mem_wr) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : pat_line(mem_addr);
      end
    end else cnt = 0;
  end

  logic mv [32], md [32];
  logic [21:0] mt [32];
  logic [255:0] ml [32];

  task automatic op(input logic [31:0] a, input logic w, input logic [31:0] d,
                    output int stalls, output logic [31:0] rd);
    @(negedge clk);
    addr = a; mr = !w; mw = w; wdata = d; stalls = 0;
    #1;
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stall) begin
      checks++;
      failures++;
      $display("FAIL stall timeout: addr %0h still stalled after %0d cycles", a, stalls);
    end
    rd = p1_data;
    @(posedge clk);
    #1;
    mr = 0; mw = 0;
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic miss, output logic wb, output logic [31:0] wb_addr,
                     output logic [255:0] wb_data, output logic [31:0] rd);
    int bt, be, n, stalls;
    int idx;
    logic e_miss, e_wb;
    logic [31:0] e_wb_addr, la;
    logic [255:0] e_wb_data;
    idx = int'(a[9:5]);
    la = {a[31:5], 5'b0};
    e_miss = !(mv[idx] && mt[idx] == a[31:10]);
    e_wb = e_miss && mv[idx] && md[idx];
    e_wb_addr = {mt[idx], a[9:5], 5'b0};
    e_wb_data = ml[idx];
    if (e_wb) ref_mem[e_wb_addr] = ml[idx];
    if (e_miss) begin
      ml[idx] = ref_mem.exists(la) ? ref_mem[la] : pat_line(la);
      mv[idx] = 1; md[idx] = 0; mt[idx] = a[31:10];
    end
    if (w) begin
      ml[idx][a[4:2]*32 +: 32] = d;
      md[idx] = 1;
    end
    bt = txq.size();
    be = en_rises;
    op(a, w, d, stalls, rd);
    n = txq.size() - bt;
    miss = stalls > 0;
    wb = n > 0 && txq[bt].w;
    wb_addr = n > 0 ? txq[bt].a : 0;
    wb_data = n > 0 ? txq[bt].d : 0;
    chk({name, " miss"}, miss, e_miss);
    chk({name, " txn count"}, n, int'(e_miss) + int'(e_wb));
    chk({name, " enable rises"}, en_rises - be, int'(e_miss));
    if (n == int'(e_miss) + int'(e_wb)) begin
      if (e_wb) begin
        chk({name, " wb write"}, txq[bt].w, 1);
        chk({name, " wb addr"}, txq[bt].a, e_wb_addr);
        chk({name, " wb data"}, txq[bt].d, e_wb_data);
      end
      if (e_miss) begin
        chk({name, " refill write"}, txq[bt+n-1].w, 0);
        chk({name, " refill addr"}, txq[bt+n-1].a, la);
      end
    end
    if (!w) chk({name, " rdata"}, rd, ml[idx][a[4:2]*32 +: 32]);
  endtask

  typedef struct {
    logic [31:0] a; logic w; logic [31:0] d;
    logic miss; logic wb; logic [31:0] wb_addr; int wb_k; logic [31:0] wb_v; logic [31:0] rd;
  } vec_t;
  vec_t tbl [9];

  initial begin
    logic miss, wb;
    logic [31:0] wb_addr, rd;
    logic [255:0] wb_data;
    for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; mt[i] = 0; ml[i] = 0; end
    tbl[0] = '{32'h408,  0, 0,            1, 0, 0,       0, 0,            32'hAA};
    tbl[1] = '{32'h408,  1, 32'h12345678, 0, 0, 0,       0, 0,            0};
    tbl[2] = '{32'h408,  0, 0,            0, 0, 0,       0, 0,            32'h12345678};
    tbl[3] = '{32'h808,  0, 0,            1, 1, 32'h400, 2, 32'h12345678, pat(32'h808)};
    tbl[4] = '{32'hC00,  0, 0,            1, 0, 0,       0, 0,            pat(32'hC00)};
    tbl[5] = '{32'h1014, 1, 32'hDEADBEEF, 1, 0, 0,       0, 0,            0};
    tbl[6] = '{32'h1014, 0, 0,            0, 0, 0,       0, 0,            32'hDEADBEEF};
    tbl[7] = '{32'h1010, 0, 0,            0, 0, 0,       0, 0,            pat(32'h1010)};
    tbl[8] = '{32'h408,  0, 0,            1, 1, 32'h1000, 5, 32'hDEADBEEF, 32'h12345678};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset stall", stall, 0);
    chk("reset mem_enable", mem_en, 0);
    chk("reset mem_write", mem_wr, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_data", mem_wdata, 0);
    chk("reset p1_data", p1_data, 0);

    for (int i = 0; i < 9; i++) begin
      run($sformatf("vec%0d", i), tbl[i].a, tbl[i].w, tbl[i].d, miss, wb, wb_addr, wb_data, rd);
      chk($sformatf("vec%0d table miss", i), miss, tbl[i].miss);
      chk($sformatf("vec%0d table wb", i), wb, tbl[i].wb);
      if (tbl[i].wb) begin
        chk($sformatf("vec%0d table wb addr", i), wb_addr, tbl[i].wb_addr);
        chk($sformatf("vec%0d table wb word", i), wb_data[tbl[i].wb_k*32 +: 32], tbl[i].wb_v);
      end
      if (!tbl[i].w) chk($sformatf("vec%0d table rdata", i), rd, tbl[i].rd);
    end

    run("dirty 408", 32'h408, 1, 32'hCAFEF00D, miss, wb, wb_addr, wb_data, rd);
    chk("dirty 408 hit", miss, 0);
    auto_en = 0;
    @(negedge clk);
    addr = 32'h808; mr = 1; mw = 0;
    #1;
    for (int i = 0; i < 50 && !(mem_en && mem_wr); i++) begin
      @(negedge clk);
      #1;
    end
    chk("abort reached writeback", mem_en && mem_wr, 1);
    chk("abort wb addr", mem_addr, 32'h400);
    @(negedge clk);
    rst = 1; mr = 0;
    @(posedge clk);
    #1;
    rst = 0;
    chk("abort mem_enable", mem_en, 0);
    chk("abort mem_write", mem_wr, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort stall", stall, 0);
    man_ack = 1;
    @(posedge clk);
    #1;
    man_ack = 0;
    chk("late ack mem_enable", mem_en, 0);
    chk("late ack stall", stall, 0);
    @(posedge clk);
    #1;
    chk("late ack mem_enable later", mem_en, 0);
    for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; end
    auto_en = 1;
    run("re-miss 408", 32'h408, 0, 0, miss, wb, wb_addr, wb_data, rd);
    chk("re-miss 408 missed", miss, 1);
    chk("re-miss 408 no wb", wb, 0);
    chk("re-miss 408 rdata", rd, 32'h12345678);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      logic rw;
      ra = {20'(0), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b0};
      rw = $urandom_range(0, 2) == 0;
      run($sformatf("rand%0d", i), ra, rw, $urandom, miss, wb, wb_addr, wb_data, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
